// File: rtl/chn_pkg.sv
// Shared constants for the chn_bridge source/destination channel FIFOs.
package chn_pkg;

    localparam int unsigned DW_DEF   = 64;
    localparam int unsigned AW_DEF   = 4;
    localparam int unsigned CNT_W    = 24;
    localparam int unsigned TAG_LAST = DW_DEF;
    localparam int unsigned IDX_SRC  = 0;
    localparam int unsigned IDX_DST  = 1;

endpackage

// File: rtl/chn_if.sv
// Signal bundle between the ss engine / processing module and chn_bridge.
interface chn_if
    import chn_pkg::*;
#(
    parameter int unsigned DW = DW_DEF,
    parameter int unsigned AW = AW_DEF
) ();

    logic              m_reset;
    logic [CNT_W-1:0]  dc;
    logic              ss_xfer_src;
    logic [DW-1:0]     wbs_dat_o_src;
    logic              ss_last_src;
    logic              ss_start_src;
    logic              ss_stop_src;
    logic              ss_end_src;
    logic              m_src_getn;
    logic [DW-1:0]     m_src;
    logic              m_src_last;
    logic              m_src_almost_empty;
    logic              m_src_empty;
    logic              m_dst_putn;
    logic [DW-1:0]     m_dst;
    logic              m_dst_last;
    logic              m_dst_almost_full;
    logic              m_dst_full;
    logic              m_endn;
    logic              ss_xfer_dst;
    logic [DW-1:0]     wbs_dat_i_dst;
    logic              ss_start_dst;
    logic              ss_stop_dst;
    logic              ss_end_dst;
    logic [AW:0]       src_level;
    logic [AW:0]       dst_level;
    logic [1:0]        ovf;
    logic [1:0]        udf;

    modport master (
        output m_reset, dc, ss_xfer_src, wbs_dat_o_src, ss_last_src, m_src_getn,
               m_dst_putn, m_dst, m_dst_last, m_endn, ss_xfer_dst,
        input  ss_start_src, ss_stop_src, ss_end_src, m_src, m_src_last,
               m_src_almost_empty, m_src_empty, m_dst_almost_full, m_dst_full,
               wbs_dat_i_dst, ss_start_dst, ss_stop_dst, ss_end_dst,
               src_level, dst_level, ovf, udf
    );

    modport slave (
        input  m_reset, dc, ss_xfer_src, wbs_dat_o_src, ss_last_src, m_src_getn,
               m_dst_putn, m_dst, m_dst_last, m_endn, ss_xfer_dst,
        output ss_start_src, ss_stop_src, ss_end_src, m_src, m_src_last,
               m_src_almost_empty, m_src_empty, m_dst_almost_full, m_dst_full,
               wbs_dat_i_dst, ss_start_dst, ss_stop_dst, ss_end_dst,
               src_level, dst_level, ovf, udf
    );

endinterface

// File: rtl/chn_fifo.sv
// First-word-fall-through register FIFO with level, threshold flags and
// single-cycle overflow/underflow pulses for the bridge to accumulate.
module chn_fifo #(
    parameter int unsigned W     = 65,
    parameter int unsigned AW    = 4,
    parameter int unsigned AE_TH = 2,
    parameter int unsigned AF_TH = (1 << AW) - 2
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          wr,
    input  logic [W-1:0]  din,
    input  logic          rd,
    output logic [W-1:0]  dout,
    output logic [AW:0]   level,
    output logic          empty,
    output logic          full,
    output logic          almost_empty,
    output logic          almost_full,
    output logic          wr_acc,
    output logic          ovf_p,
    output logic          udf_p
);

    localparam int unsigned DEPTH = 1 << AW;
    localparam int unsigned LW    = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] waddr;
    logic [AW-1:0] raddr;
    logic          rd_acc;

    assign empty        = (level == '0);
    assign full         = (level == LW'(DEPTH));
    assign almost_empty = (level <= LW'(AE_TH));
    assign almost_full  = (level >= LW'(AF_TH));

    // A full FIFO still takes a write when a read frees a slot in the same cycle.
    assign rd_acc = rd & ~empty;
    assign wr_acc = wr & (~full | rd_acc);
    assign ovf_p  = wr & ~wr_acc;
    assign udf_p  = rd & empty;
    assign dout   = mem[raddr];

    always_ff @(posedge clk) begin
        if (clr) begin
            waddr <= '0;
            raddr <= '0;
            level <= '0;
        end else begin
            if (wr_acc) waddr <= waddr + AW'(1);
            if (rd_acc) raddr <= raddr + AW'(1);
            case ({wr_acc, rd_acc})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc && !clr) mem[waddr] <= din;
    end

endmodule

// File: rtl/chn_bridge.sv
// Source/destination channel bridge between the ss engine and a processing module.
// Optional descriptor-count terminator built when CHN_XFER_CNT_EN is defined.
module chn_bridge
    import chn_pkg::*;
#(
    parameter int unsigned DW    = DW_DEF,
    parameter int unsigned AW    = AW_DEF,
    parameter int unsigned AE_TH = 2,
    parameter int unsigned AF_TH = (1 << AW) - 2
) (
    input  logic  wb_clk_i,
    input  logic  wb_rst_i,
    chn_if.slave  bus
);

    localparam int unsigned DEPTH = 1 << AW;
    localparam int unsigned LW    = AW + 1;
    localparam int unsigned EW    = DW + 1;

    logic          clr;
    logic          terminated;
    logic [EW-1:0] src_head, dst_head;
    logic [AW:0]   src_level, dst_level;
    logic          src_empty, src_full, src_ae, src_af, src_wr_acc, src_ovf, src_udf;
    logic          dst_empty, dst_full, dst_ae, dst_af, dst_wr_acc, dst_ovf, dst_udf;
    logic [1:0]    ovf_q, udf_q;

    assign clr = wb_rst_i | bus.m_reset;

    chn_fifo #(.W(EW), .AW(AW), .AE_TH(AE_TH), .AF_TH(AF_TH)) u_src (
        .clk(wb_clk_i), .clr(clr),
        .wr(bus.ss_xfer_src & ~terminated), .din({bus.ss_last_src, bus.wbs_dat_o_src}),
        .rd(~bus.m_src_getn), .dout(src_head), .level(src_level),
        .empty(src_empty), .full(src_full), .almost_empty(src_ae), .almost_full(src_af),
        .wr_acc(src_wr_acc), .ovf_p(src_ovf), .udf_p(src_udf)
    );

    chn_fifo #(.W(EW), .AW(AW), .AE_TH(AE_TH), .AF_TH(AF_TH)) u_dst (
        .clk(wb_clk_i), .clr(clr),
        .wr(~bus.m_dst_putn), .din({bus.m_dst_last, bus.m_dst}),
        .rd(bus.ss_xfer_dst), .dout(dst_head), .level(dst_level),
        .empty(dst_empty), .full(dst_full), .almost_empty(dst_ae), .almost_full(dst_af),
        .wr_acc(dst_wr_acc), .ovf_p(dst_ovf), .udf_p(dst_udf)
    );

`ifdef CHN_XFER_CNT_EN
    logic [CNT_W-1:0] cnt;

    // Terminate on the accepted write that reaches the descriptor count.
    always_ff @(posedge wb_clk_i) begin
        if (clr) begin
            cnt        <= '0;
            terminated <= 1'b0;
        end else if (src_wr_acc) begin
            cnt <= cnt + CNT_W'(1);
            if ((bus.dc != '0) && (cnt + CNT_W'(1) == bus.dc)) terminated <= 1'b1;
        end
    end
`else
    logic unused_cfg;
    assign terminated = 1'b0;
    assign unused_cfg = ^{bus.dc, src_wr_acc};
`endif

    always_ff @(posedge wb_clk_i) begin
        if (clr) begin
            ovf_q <= '0;
            udf_q <= '0;
        end else begin
            ovf_q[IDX_SRC] <= ovf_q[IDX_SRC] | src_ovf;
            ovf_q[IDX_DST] <= ovf_q[IDX_DST] | dst_ovf;
            udf_q[IDX_SRC] <= udf_q[IDX_SRC] | src_udf;
            udf_q[IDX_DST] <= udf_q[IDX_DST] | dst_udf;
        end
    end

    assign bus.m_src              = src_head[DW-1:0];
    assign bus.m_src_last         = src_head[DW];
    assign bus.m_src_empty        = src_empty;
    assign bus.m_src_almost_empty = src_ae;
    assign bus.ss_start_src       = (src_level < LW'(DEPTH / 2)) & ~terminated;
    assign bus.ss_stop_src        = src_af | terminated;
    assign bus.ss_end_src         = terminated;

    assign bus.wbs_dat_i_dst      = dst_head[DW-1:0];
    assign bus.m_dst_almost_full  = dst_af;
    assign bus.m_dst_full         = dst_full;
    assign bus.ss_start_dst       = (dst_level >= LW'(DEPTH / 2)) | (~bus.m_endn & ~dst_empty);
    assign bus.ss_stop_dst        = dst_af;
    assign bus.ss_end_dst         = ~dst_empty & dst_head[DW];

    assign bus.src_level = src_level;
    assign bus.dst_level = dst_level;
    assign bus.ovf       = ovf_q;
    assign bus.udf       = udf_q;

    logic unused_st;
    assign unused_st = src_full ^ dst_ae ^ dst_wr_acc;

endmodule

// File: doc/chn_bridge.md
# chn_bridge

Parametrised successor to the fixed 64-bit, 16-deep channel bridge between the Wishbone stream-slave (ss) engine and a processing module (m). It holds one source FIFO (ss→m) and one destination FIFO (m→ss). Each entry carries data plus a `last` tag. The block drives the start/stop/end flow-control strobes toward the ss engine. New relative to the previous generation: generic width and depth, programmable thresholds, FIFO level outputs, sticky overflow/underflow flags, and an optional descriptor-count terminator on the source side.

## Interface
Parameters:
- DW, 64, data width per FIFO entry (excluding tag)
- AW, 4, log2 FIFO depth; DEPTH = 2**AW
- AE_TH, 2, almost-empty threshold (level ≤ AE_TH)
- AF_TH, DEPTH-2, almost-full threshold (level ≥ AF_TH)

Ports:
- wb_clk_i  in  1  single clock; all logic on rising edge
- wb_rst_i  in  1  reset, synchronous, active-high
- m_reset  in  1  synchronous clear of both FIFOs, counter and flags
- dc  in  24  source word count for the current descriptor; 0 = unlimited
- ss_xfer_src  in  1  ss writes one word into source FIFO
- wbs_dat_o_src  in  DW  source write data
- ss_last_src  in  1  last tag for source write
- ss_start_src / ss_stop_src / ss_end_src  out  1  source flow control
- m_src_getn  in  1  active-low source read
- m_src  out  DW  source head data
- m_src_last  out  1  source head tag
- m_src_almost_empty / m_src_empty  out  1  source status
- m_dst_putn  in  1  active-low destination write
- m_dst  in  DW  destination write data
- m_dst_last  in  1  destination tag
- m_dst_almost_full / m_dst_full  out  1  destination status
- m_endn  in  1  active-low: module finished, flush destination
- ss_xfer_dst  in  1  ss reads one word from destination FIFO
- wbs_dat_i_dst  out  DW  destination head data
- ss_start_dst / ss_stop_dst / ss_end_dst  out  1  destination flow control
- src_level / dst_level  out  AW+1  occupancy, 0..DEPTH
- ovf  out  2  sticky overflow {dst,src}
- udf  out  2  sticky underflow {dst,src}

## Operation
- Each FIFO has DW+1 bits per entry (tag in MSB), a register array, wrap-around pointers of width AW, and a level counter of width AW+1.
- Head data is first-word-fall-through: the output is an asynchronous read at raddr and is valid whenever the FIFO is not empty.
- A write when full is discarded and sets the matching ovf bit. A read when empty is ignored and sets the matching udf bit. Both flags are sticky until wb_rst_i or m_reset.
- A simultaneous read and write on a non-empty, non-full FIFO leaves the level unchanged. When full, a simultaneous read and write are both accepted. When empty, the write is accepted and the read sets udf.
- Source side:
  - ss_start_src = level < DEPTH/2 and not terminated.
  - ss_stop_src = level ≥ AF_TH or terminated.
- Destination side:
  - ss_start_dst = level ≥ DEPTH/2, or (!m_endn and not empty).
  - ss_stop_dst = m_dst_almost_full.
  - ss_end_dst = !empty and head tag.
- Status outputs: m_src_almost_empty = level ≤ AE_TH; m_dst_almost_full = level ≥ AF_TH; m_dst_full = level == DEPTH.
- Terminator (when compiled in):
  - A 24-bit count increments on each accepted ss_xfer_src.
  - When an accepted write makes count == dc (dc ≠ 0), `terminated` is registered; the write itself is still stored.
  - While terminated, further writes are dropped and do not set ovf.

## Timing
- All status outputs, levels and flags are registered or derived combinationally from registered state. A write or read affects them on the cycle after the qualifying edge.
- Write-to-read latency: a word written at edge N is visible on m_src / wbs_dat_i_dst after edge N.
- ss_end_src asserts the cycle after the terminating write and holds until m_reset or wb_rst_i.
- Reset (wb_rst_i or m_reset) sets the following values:
  - Pointers, levels, count, ovf, udf and terminated = 0.
  - empty = 1, almost_empty = 1, full = 0, almost_full = 0.
  - ss_start_src = 1; ss_start_dst, ss_end_* and ss_stop_* = 0.
  - Data outputs are don't-care.
- wb_rst_i or m_reset mid-transfer overrides any same-cycle read or write.

## Configuration
- CHN_XFER_CNT_EN defined: descriptor counter and terminator are built; ss_end_src behaves as above.
- CHN_XFER_CNT_EN not defined: no counter; terminated is held at 0; ss_end_src is tied 0; dc is ignored.

## Structure
- Package chn_pkg:
  - TAG_LAST bit position.
  - Default DW/AW constants.
  - Index constants for the ovf/udf bit order (SRC = 0, DST = 1).
- One sub-module, chn_fifo (parametrised by width, AW, AE_TH, AF_TH), instantiated twice. It provides level, flags and the ovf/udf pulses; the flow-control logic and counter stay in the top level.

## Test plan
- Reset, then 16 ss_xfer_src writes (AW=4) → src_level = 16, ss_stop_src = 1 from write 14, ss_start_src = 0 from write 8; a 17th write sets ovf[0] and leaves the level at 16.
- Write words 0x1..0x5 with last on word 5, then read all → m_src returns 1..5 in order, m_src_last = 1 only on 5, then empty = 1.
- Simultaneous put and xfer on dst at level 8 for 20 cycles → dst_level stays 8, ovf = udf = 0, with pointer wrap-around covered.
- dc = 3 with CHN_XFER_CNT_EN defined: 5 source writes → src_level = 3, ss_end_src = 1 from the cycle after write 3, ss_stop_src = 1, no ovf; m_reset clears all of it.
- dst level 2, m_endn = 0 → ss_start_dst = 1; on reading the tagged head, ss_end_dst = 1; an extra read on empty sets udf[1].
- m_reset asserted on the same cycle as a write → level stays 0 and all flags are 0.
